// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared symbol, width and lane-sync state definitions for the phy_rx path
package phy_rx_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_BC = 8'hBC;
  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/phy_rx_comma_det.sv
// phy_rx_comma_det: MSB-first deserialising shift register with comma compare
module phy_rx_comma_det
  import phy_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_BC
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] sr,
  output logic              comma_hit
);
  always_ff @(posedge clk_8f or negedge reset)
    if (!reset) sr <= '0;
    else sr <= {sr[BYTE_W-2:0], data_in};
  assign comma_hit = sr == COMMA;
endmodule

// File: rtl/phy_rx_lane_sync.sv
// phy_rx_lane_sync: comma hunt, byte alignment lock and byte delivery for one serial lane
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA       = COMMA_BC,
  parameter int                BC_REQUIRED = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              byte_strobe
);
  localparam bit         ONE_BC  = BC_REQUIRED == 1;
  localparam logic [2:0] BC_LAST = 3'(BC_REQUIRED - 1);
  state_t state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt, bc_cnt, bc_cnt_nxt;
  logic [BYTE_W-1:0] sr;
  logic comma_hit, boundary, cap;
  phy_rx_comma_det #(.COMMA(COMMA)) u_det (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .sr       (sr),
    .comma_hit(comma_hit)
  );
  assign boundary = state != SEARCH && bit_cnt == 3'd0;
  assign cap      = state == ACTIVE && boundary;
  assign active   = state == ACTIVE;
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = state == SEARCH ? 3'd0 : bit_cnt + 3'd1;
    bc_cnt_nxt  = bc_cnt;
    case (state)
      SEARCH: if (comma_hit) begin
        state_nxt   = ONE_BC ? ACTIVE : ALIGN;
        bit_cnt_nxt = 3'd1;
        bc_cnt_nxt  = ONE_BC ? 3'd0 : 3'd1;
      end
      ALIGN: if (boundary) begin
        state_nxt   = !comma_hit ? SEARCH : bc_cnt == BC_LAST ? ACTIVE : ALIGN;
        bc_cnt_nxt  = comma_hit && bc_cnt != BC_LAST ? bc_cnt + 3'd1 : 3'd0;
        bit_cnt_nxt = comma_hit ? bit_cnt_nxt : 3'd0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_8f or negedge reset)
    if (!reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bc_cnt      <= bc_cnt_nxt;
      byte_strobe <= cap;
      if (cap) begin
        data_out  <= sr;
        valid_out <= !comma_hit;
      end
    end
endmodule

// File: tb/tb_phy_rx_lane_sync.sv
// tb_phy_rx_lane_sync: scoreboard bench for comma lock, byte delivery and reset recovery
module tb_phy_rx_lane_sync;
  import phy_rx_pkg::*;
  logic clk_8f = 1'b0, reset = 1'b0, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, active, byte_strobe;
  int checks = 0, failures = 0, cyc = 0, last_sb = -1;
  logic [8:0] exp_q[$];
  always #5 clk_8f = ~clk_8f;
  always @(posedge clk_8f) cyc++;
  phy_rx_lane_sync #(.COMMA(8'hBC), .BC_REQUIRED(4)) dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .byte_strobe(byte_strobe)
  );
  task automatic step(input logic b);
    logic [8:0] e;
    data_in = b;
    @(posedge clk_8f);
    #1;
    if (byte_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: strobe with data_out=%02h valid=%0b, required no strobe", data_out, valid_out);
      end else begin
        e = exp_q.pop_front();
        if ({data_out, valid_out} !== e) begin
          failures++;
          $display("FAIL sb_byte: data_out=%02h valid=%0b, required data_out=%02h valid=%0b", data_out, valid_out, e[8:1], e[0]);
        end
      end
      if (last_sb >= 0) begin
        checks++;
        if (cyc - last_sb != 8) begin
          failures++;
          $display("FAIL strobe_spacing: %0d cycles, required 8", cyc - last_sb);
        end
      end
      last_sb = cyc;
    end
  endtask
  task automatic send_byte(input logic [7:0] v, input bit cap);
    if (cap) exp_q.push_back({v, v != COMMA_BC});
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask
  task automatic apply_reset();
    @(negedge clk_8f);
    reset = 1'b0;
    data_in = 1'b0;
    exp_q.delete();
    last_sb = -1;
    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;
    repeat (3) step(1'b0);
  endtask
  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d bytes never delivered, required 0", name, exp_q.size());
    end
  endtask
  task automatic check_active(input string name, input logic req);
    checks++;
    if (active !== req) begin
      failures++;
      $display("FAIL %s: active=%0b, required %0b", name, active, req);
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      data_in = 1'($urandom);
      @(posedge clk_8f);
      #1;
      checks++;
      if ({data_out, valid_out, active, byte_strobe} !== 11'd0) begin
        failures++;
        $display("FAIL reset_outputs: data_out=%02h valid=%0b active=%0b strobe=%0b, required all 0", data_out, valid_out, active, byte_strobe);
      end
    end
    @(negedge clk_8f);
    reset = 1'b1;
    repeat (3) step(1'b0);
  endtask
  task automatic test_lock();
    logic [7:0] v = 8'h55;
    repeat (4) send_byte(8'hBC, 1'b0);
    check_active("lock_before", 1'b0);
    exp_q.push_back({v, 1'b1});
    step(v[7]);
    check_active("lock_rise", 1'b1);
    for (int i = 6; i >= 0; i--) step(v[i]);
    send_byte(8'hA3, 1'b1);
    step(1'b0);
    step(1'b0);
    checks++;
    if ({data_out, valid_out, byte_strobe} !== {8'hA3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL lock_hold: data_out=%02h valid=%0b strobe=%0b, required A3 1 0", data_out, valid_out, byte_strobe);
    end
    check_sb_empty("lock_sb");
  endtask
  task automatic test_abort();
    apply_reset();
    repeat (3) send_byte(8'hBC, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (4) send_byte(8'hBC, 1'b0);
    check_active("abort_stays_off", 1'b0);
    send_byte(8'h77, 1'b1);
    step(1'b0);
    check_active("abort_relock", 1'b1);
    check_sb_empty("abort_sb");
  endtask
  task automatic test_offset();
    apply_reset();
    step(1'b0);
    step(1'b1);
    step(1'b0);
    repeat (4) send_byte(8'hBC, 1'b0);
    send_byte(8'h3C, 1'b1);
    check_active("offset_active", 1'b1);
  endtask
  task automatic test_back_to_back();
    send_byte(8'h11, 1'b1);
    send_byte(8'hBC, 1'b1);
    send_byte(8'h22, 1'b1);
    step(1'b0);
    check_sb_empty("b2b_sb");
  endtask
  task automatic test_reset_mid();
    step(1'b1);
    step(1'b1);
    step(1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, valid_out, active, byte_strobe} !== 11'd0) begin
      failures++;
      $display("FAIL midreset_clear: data_out=%02h valid=%0b active=%0b strobe=%0b, required all 0", data_out, valid_out, active, byte_strobe);
    end
    exp_q.delete();
    last_sb = -1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;
    repeat (3) step(1'b0);
    repeat (3) send_byte(8'hBC, 1'b0);
    check_active("midreset_3bc", 1'b0);
    send_byte(8'hBC, 1'b0);
    check_active("midreset_4bc_pre", 1'b0);
    send_byte(8'h5A, 1'b1);
    check_active("midreset_4bc", 1'b1);
    step(1'b0);
    check_sb_empty("midreset_sb");
  endtask
  initial begin
    test_reset();
    test_lock();
    test_abort();
    test_offset();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
